tri_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared, pulled-up (tri1) data bus driven by several tri-state agents.
- Grants exactly one agent the bus at a time and generates the per-agent output enables.
- Enforces a hold limit per tenure and a turnaround gap between owners.
- Checks that the bus floats to its pull-up value during turnaround.
- Sits between the agents' request logic and their tri-state drivers on the bus.

---
 rtl/tri_bus_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 39 +++
 rtl/tri_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_bus_arb_pkg.sv
// Shared definitions for the tri-state bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, TURN)
//   owner_w()   : width of an agent index for a given agent count
//   idle_value(): all-ones pattern a floating pulled-up bus must show
package tri_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int MAX_BUS_W = 64;

    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pull-up value of a w-bit bus; callers cast down to their own width.
    function automatic logic [MAX_BUS_W-1:0] idle_value(input int w);
        logic [MAX_BUS_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_BUS_W; i++) begin
            if (i < w) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_i     : request vector
//   last_i    : index of the previous winner (lowest priority this round)
//   win_oh_o  : one-hot winner
//   win_idx_o : winner index
//   valid_o   : at least one request present
// The search starts at last_i+1 and wraps modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last_i) + i) % N;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o            = 1'b1;
                win_oh_o[cand_idx] = 1'b1;
                win_idx_o          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter / sequencer for a pulled-up shared tri-state bus.
//   clk, rst_n  : clock (rising edge), async active-low reset
//   req         : per-agent level request
//   done        : per-agent release pulse (only the owner's is honoured)
//   bus_in      : sampled bus value, checked for float during turnaround
//   grant       : one-hot ownership
//   drive_en    : tri-state output enables (identical to grant)
//   owner_id    : index of current / last owner
//   bus_busy    : high while an owner holds the bus
//   timeout_err : one-cycle pulse when a tenure is cut at MAX_HOLD
//   float_err   : one-cycle pulse after a turnaround cycle with bus != all-ones
//   dbg_state   : current FSM state, for observation only
// Valid/ready-style contract: an agent owns the bus exactly while its grant
// bit is high; it keeps req high for as long as it wants the bus and ends
// its tenure either with a done pulse or by dropping req.
module tri_bus_arbiter
    import tri_bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            done,
    input  logic [DATA_W-1:0]             bus_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            drive_en,
    output logic [owner_w(NUM_REQ)-1:0]   owner_id,
    output logic                          bus_busy,
    output logic                          timeout_err,
    output logic                          float_err,
    output arb_state_e                    dbg_state
);

    localparam int OWNER_W = owner_w(NUM_REQ);
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam int TURN_W  = $clog2(TURN_CYC + 1);
    localparam logic [DATA_W-1:0] IDLE_VAL = DATA_W'(idle_value(DATA_W));

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [TURN_W-1:0]    turn_q, turn_d;
    logic                 timeout_q, timeout_d;
    logic                 float_q, float_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 pick_valid;
    logic                 own_done, own_req, at_max, release_now;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (OWNER_W)
    ) u_pick (
        .req_i     (req),
        .last_i    (owner_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    assign own_done    = done[owner_q];
    assign own_req     = req[owner_q];
    assign at_max      = (hold_q == HOLD_W'(MAX_HOLD));
    assign release_now = own_done || !own_req || at_max;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        timeout_d = 1'b0;
        float_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_TURN;
                    grant_d   = '0;
                    hold_d    = '0;
                    turn_d    = TURN_W'(1);
                    // A cut only counts as a timeout if the owner had not
                    // already released on that same cycle.
                    timeout_d = at_max && !own_done && own_req;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                float_d = (bus_in != IDLE_VAL);
                if (turn_q == TURN_W'(TURN_CYC)) begin
                    turn_d = '0;
                    // Arbitrate straight out of turnaround, no IDLE bubble.
                    if (pick_valid) begin
                        state_d = ST_GRANT;
                        grant_d = pick_oh;
                        owner_d = pick_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Async reset clears grant at once so a reset mid-tenure floats the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= OWNER_W'(NUM_REQ - 1);
            hold_q    <= '0;
            turn_q    <= '0;
            timeout_q <= 1'b0;
            float_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
            float_q   <= float_d;
        end
    end

    assign grant       = grant_q;
    assign drive_en    = grant_q;
    assign owner_id    = owner_q;
    assign bus_busy    = (state_q == ST_GRANT);
    assign timeout_err = timeout_q;
    assign float_err   = float_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;
  import tri_bus_arb_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 16;
  localparam int TURN_CYC = 1;
  localparam int OW       = $clog2(NUM_REQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0] req, done, grant, drive_en;
  logic [DATA_W-1:0]  bus_in;
  logic [OW-1:0]      owner_id;
  logic               bus_busy, timeout_err, float_err;
  arb_state_e         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  tri_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .bus_in(bus_in),
    .grant(grant), .drive_en(drive_en), .owner_id(owner_id), .bus_busy(bus_busy),
    .timeout_err(timeout_err), .float_err(float_err), .dbg_state(dbg_state)
  );

  // ---------------- reference helpers ----------------
  // Round-robin rule: first request searching upward from last+1, wrapping.
  function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0; req = '0; done = '0; bus_in = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; done = '0; bus_in = 8'h00;
    repeat (2) @(negedge clk);
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b exp 0000", grant); end
    n_tests++; if (drive_en !== 4'b0000) begin n_fail++; $display("FAIL reset_drive_en: got %b exp 0000", drive_en); end
    n_tests++; if (owner_id !== OW'(NUM_REQ-1)) begin n_fail++; $display("FAIL reset_owner: got %0d exp %0d", owner_id, NUM_REQ-1); end
    n_tests++; if ({bus_busy, timeout_err, float_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {bus_busy, timeout_err, float_err}); end
    rst_n = 1'b1; req = '0; bus_in = '1;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    @(negedge clk);
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b exp 0001", grant); end
    n_tests++; if (drive_en !== 4'b0001) begin n_fail++; $display("FAIL single_drive_en: got %b exp 0001", drive_en); end
    n_tests++; if (owner_id !== OW'(0)) begin n_fail++; $display("FAIL single_owner: got %0d exp 0", owner_id); end
    n_tests++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", bus_busy); end
    done = 4'b0001;
    @(negedge clk);
    n_tests++; if ({grant, bus_busy} !== 5'b0) begin n_fail++; $display("FAIL single_release: got %b exp 00000", {grant, bus_busy}); end
    done = '0; req = '0;
    repeat (2) begin
      @(negedge clk);
      n_tests++; if ({grant, bus_busy} !== 5'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 00000", {grant, bus_busy}); end
    end
  endtask

  task automatic test_rotation();
    int own;
    apply_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      own = t % NUM_REQ;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        n_tests++; if (grant !== onehot(own)) begin n_fail++; $display("FAIL rot_grant t%0d k%0d: got %b exp %b", t, k, grant, onehot(own)); end
        n_tests++; if (drive_en !== grant) begin n_fail++; $display("FAIL rot_drive_en: got %b exp %b", drive_en, grant); end
        if (k == 3) done = onehot(own);
      end
      @(negedge clk);
      n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rot_gap t%0d: got %b exp 0000", t, grant); end
      done = '0;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0100;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      @(negedge clk);
      n_tests++; if ({grant, timeout_err} !== 5'b01000) begin n_fail++; $display("FAIL to_hold k%0d: got %b exp 01000", k, {grant, timeout_err}); end
      done = (k == 5) ? 4'b0011 : 4'b0000;  // non-owner done must be ignored
    end
    @(negedge clk);
    n_tests++; if ({grant, timeout_err} !== 5'b00001) begin n_fail++; $display("FAIL to_cut: got %b exp 00001", {grant, timeout_err}); end
    @(negedge clk);
    n_tests++; if ({grant, timeout_err} !== 5'b01000) begin n_fail++; $display("FAIL to_regrant: got %b exp 01000", {grant, timeout_err}); end
    n_tests++; if (owner_id !== OW'(2)) begin n_fail++; $display("FAIL to_owner: got %0d exp 2", owner_id); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_float();
    apply_reset();
    req = 4'b0001; bus_in = 8'h00;
    @(negedge clk);
    done = 4'b0001;
    @(negedge clk);
    n_tests++; if ({grant, float_err} !== 5'b0) begin n_fail++; $display("FAIL fl_grant_nofloat: got %b exp 00000", {grant, float_err}); end
    done = '0; bus_in = 8'hF7;
    @(negedge clk);
    n_tests++; if (float_err !== 1'b1) begin n_fail++; $display("FAIL fl_f7: got %b exp 1", float_err); end
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL fl_regrant: got %b exp 0001", grant); end
    bus_in = 8'h00; done = 4'b0001;
    @(negedge clk);
    n_tests++; if (float_err !== 1'b0) begin n_fail++; $display("FAIL fl_pulse_len: got %b exp 0", float_err); end
    bus_in = 8'hFF; done = '0; req = '0;
    @(negedge clk);
    n_tests++; if (float_err !== 1'b0) begin n_fail++; $display("FAIL fl_ff: got %b exp 0", float_err); end
    bus_in = 8'hF7;
    @(negedge clk);
    n_tests++; if (float_err !== 1'b0) begin n_fail++; $display("FAIL fl_idle: got %b exp 0", float_err); end
    bus_in = '1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0010;
    @(negedge clk);
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL ar_grant: got %b exp 0010", grant); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({grant, drive_en, bus_busy} !== 9'b0) begin n_fail++; $display("FAIL ar_drop: got %b exp 0", {grant, drive_en, bus_busy}); end
    n_tests++; if (owner_id !== OW'(NUM_REQ-1)) begin n_fail++; $display("FAIL ar_owner_rst: got %0d exp %0d", owner_id, NUM_REQ-1); end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1000;
    @(negedge clk);
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL ar_regrant: got %b exp 1000", grant); end
    n_tests++; if (owner_id !== OW'(3)) begin n_fail++; $display("FAIL ar_owner: got %0d exp 3", owner_id); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_done_at_max();
    apply_reset();
    req = 4'b0011;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      @(negedge clk);
      n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL dm_hold k%0d: got %b exp 0001", k, grant); end
      if (k == MAX_HOLD) begin done = 4'b0001; req = 4'b0010; end
    end
    @(negedge clk);
    n_tests++; if ({grant, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL dm_release: got %b exp 00000", {grant, timeout_err}); end
    done = '0;
    @(negedge clk);
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL dm_next: got %b exp 0010", grant); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- randomized run against the tenure-level model ----------------
  task automatic test_random();
    int len_a [NUM_REQ];
    int cnt_a [NUM_REQ];
    bit busy_a [NUM_REQ];
    bit drop_a [NUM_REQ];
    logic [NUM_REQ-1:0] g, g_prev, req_prev;
    int since_rel, last_own, exp_own, gap_exp, r;
    bit exp_float, is_turn;
    logic [7:0] exp_len;

    apply_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      len_a[i] = 0; cnt_a[i] = 0; busy_a[i] = 0; drop_a[i] = 0;
    end
    g_prev = '0; req_prev = '0; since_rel = 1000; last_own = NUM_REQ - 1;
    gap_exp = 3; exp_float = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = grant;
      n_tests++; if (drive_en !== g) begin n_fail++; $display("FAIL rnd_drive_en c%0d: got %b exp %b", c, drive_en, g); end
      n_tests++; if (!$onehot0(g)) begin n_fail++; $display("FAIL rnd_onehot c%0d: got %b exp one-hot", c, g); end
      n_tests++; if (bus_busy !== (g != '0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b exp %b", c, bus_busy, g != '0); end
      n_tests++; if (float_err !== exp_float) begin n_fail++; $display("FAIL rnd_float c%0d: got %b exp %b", c, float_err, exp_float); end
      if (gap_exp == 1 || gap_exp == 3) begin
        n_tests++; if (g !== '0) begin n_fail++; $display("FAIL rnd_gap_zero c%0d: got %b exp 0000", c, g); end
      end else if (gap_exp == 2) begin
        n_tests++; if (g === '0) begin n_fail++; $display("FAIL rnd_gap_grant c%0d: got %b exp nonzero", c, g); end
      end
      if (g_prev != '0 && g != '0) begin
        n_tests++; if (g !== g_prev) begin n_fail++; $display("FAIL rnd_switch c%0d: got %b exp %b", c, g, g_prev); end
      end
      // tenure end
      if (g_prev != '0 && g == '0) begin
        n_tests++; if (timeout_err !== (len_a[last_own] > MAX_HOLD)) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b exp %b", c, timeout_err, len_a[last_own] > MAX_HOLD); end
        exp_len = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        n_tests++; if (8'(cnt_a[last_own]) !== exp_len) begin n_fail++; $display("FAIL rnd_tenure c%0d: got %0d exp %0d", c, cnt_a[last_own], exp_len); end
        busy_a[last_own] = 0;
      end else begin
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout_spur c%0d: got %b exp 0", c, timeout_err); end
      end
      // tenure start
      if (g != '0 && g_prev == '0) begin
        exp_own = rr_model(req_prev, last_own);
        n_tests++; if (g !== onehot(exp_own)) begin n_fail++; $display("FAIL rnd_winner c%0d: got %b exp %b", c, g, onehot(exp_own)); end
        if (exp_own >= 0) begin
          last_own = exp_own;
          cnt_a[last_own] = 0;
          exp_q.push_back(8'((len_a[last_own] < MAX_HOLD) ? len_a[last_own] : MAX_HOLD));
        end
      end
      n_tests++; if (owner_id !== OW'(last_own)) begin n_fail++; $display("FAIL rnd_owner c%0d: got %0d exp %0d", c, owner_id, last_own); end
      if (g != '0) cnt_a[last_own]++;

      // agents decide the inputs for the coming edge
      done = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g[i]) begin
          if (cnt_a[i] == len_a[i]) begin
            if (drop_a[i]) req[i] = 1'b0;
            else           done[i] = 1'b1;
          end
        end else begin
          if ($urandom_range(0, 7) == 0) done[i] = 1'b1;
          if (!busy_a[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              busy_a[i] = 1; req[i] = 1'b1; cnt_a[i] = 0;
              drop_a[i] = ($urandom_range(0, 4) == 0);
              r = $urandom_range(0, 9);
              if (r < 6)      len_a[i] = $urandom_range(1, 6);
              else if (r < 9) len_a[i] = MAX_HOLD - 1 + (r - 6);
              else            len_a[i] = MAX_HOLD + 5;
            end else begin
              req[i] = 1'b0;
            end
          end
        end
      end
      if (g != '0) bus_in = DATA_W'($urandom);
      else         bus_in = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom) : '1;

      // expectations for the next cycle
      if (g != '0) since_rel = 0;
      else if (since_rel < 1000) since_rel++;
      is_turn   = (g == '0) && (since_rel >= 1) && (since_rel <= TURN_CYC);
      exp_float = is_turn && (bus_in != '1);
      if (g != '0)                 gap_exp = 0;
      else if (since_rel < TURN_CYC) gap_exp = 1;
      else                          gap_exp = (req != '0) ? 2 : 3;
      req_prev = req;
      g_prev   = g;
    end
    req = '0; done = '0; bus_in = '1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    req = '0; done = '0; bus_in = '1;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_float();
    test_async_reset();
    test_done_at_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
